// File: rtl/soc_msp430_trace_collector.sv
// soc_msp430_trace_collector
//
// Collects the writeback trace of NUM_CORES MSP430 tiles. A shadow copy of R3
// is kept per core. Print (PUTC_INSN) and terminate (TERM_INSN) markers are
// queued per core as {kind, data} events. The queued events are merged
// round-robin onto one valid/ready stream. Termination, overflow and an
// inactivity watchdog are reported as status flags.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   trace_valid[NUM_CORES]       retired-instruction strobe per core
//   trace_insn[16*NUM_CORES]     instruction word, core i at [16i+15:16i]
//   trace_wben[NUM_CORES]        register writeback enable
//   trace_wbreg[4*NUM_CORES]     writeback register index
//   trace_wbdata[16*NUM_CORES]   writeback data
//   ev_valid/ev_ready            merged event handshake
//   ev_core/ev_kind/ev_data      source core, 0=putc 1=terminate, payload
//   term_mask, all_term          per-core / global termination
//   overflow                     sticky per-core event-drop flag
//   timeout                      sticky watchdog expiry
module soc_msp430_trace_collector #(
    parameter int unsigned NUM_CORES  = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] PUTC_INSN  = 16'h4304,
    parameter logic [15:0] TERM_INSN  = 16'h4305,
    parameter int unsigned TIMEOUT    = 1000000,
    localparam int unsigned CORE_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CORES-1:0]      trace_valid,
    input  logic [NUM_CORES*16-1:0]   trace_insn,
    input  logic [NUM_CORES-1:0]      trace_wben,
    input  logic [NUM_CORES*4-1:0]    trace_wbreg,
    input  logic [NUM_CORES*16-1:0]   trace_wbdata,
    output logic                      ev_valid,
    input  logic                      ev_ready,
    output logic [CORE_W-1:0]         ev_core,
    output logic                      ev_kind,
    output logic [15:0]               ev_data,
    output logic [NUM_CORES-1:0]      term_mask,
    output logic                      all_term,
    output logic [NUM_CORES-1:0]      overflow,
    output logic                      timeout
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned WD_W  = (TIMEOUT > 0) ? $clog2(64'(TIMEOUT) + 1) : 1;
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CORE_W-1:0] LAST_CORE = CORE_W'(NUM_CORES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0]           r3_q      [NUM_CORES];
    logic [15:0]           r3_d      [NUM_CORES];
    logic [16:0]           mem_q     [NUM_CORES][FIFO_DEPTH];
    logic [16:0]           mem_d     [NUM_CORES][FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q  [NUM_CORES];
    logic [PTR_W-1:0]      wr_ptr_d  [NUM_CORES];
    logic [PTR_W-1:0]      rd_ptr_q  [NUM_CORES];
    logic [PTR_W-1:0]      rd_ptr_d  [NUM_CORES];
    logic [CNT_W-1:0]      cnt_q     [NUM_CORES];
    logic [CNT_W-1:0]      cnt_d     [NUM_CORES];
    logic [NUM_CORES-1:0]  term_mask_q, term_mask_d;
    logic [NUM_CORES-1:0]  overflow_q,  overflow_d;
    logic                  all_term_q,  all_term_d;
    logic                  timeout_q,   timeout_d;
    logic [WD_W-1:0]       wd_q,        wd_d;
    logic [CORE_W-1:0]     rr_ptr_q,    rr_ptr_d;
    logic                  lock_q,      lock_d;
    logic [CORE_W-1:0]     lock_core_q, lock_core_d;

    // ------------------------------------------------------------------
    // Trace decode
    // ------------------------------------------------------------------
    logic                  live      [NUM_CORES];
    logic                  wr_r3     [NUM_CORES];
    logic [15:0]           r3_new    [NUM_CORES];
    logic                  push      [NUM_CORES];
    logic [16:0]           push_data [NUM_CORES];
    logic                  term_hit  [NUM_CORES];

    always_comb begin
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            live[i]   = trace_valid[i] && !term_mask_q[i];
            wr_r3[i]  = trace_wben[i] && (trace_wbreg[4*i +: 4] == 4'd3);
            // A marker that also writes R3 reports the freshly written value.
            r3_new[i] = wr_r3[i] ? trace_wbdata[16*i +: 16] : r3_q[i];
            r3_d[i]   = (live[i] && wr_r3[i]) ? trace_wbdata[16*i +: 16] : r3_q[i];
            term_hit[i] = live[i] && (trace_insn[16*i +: 16] == TERM_INSN);
            push[i]   = term_hit[i] ||
                        (live[i] && (trace_insn[16*i +: 16] == PUTC_INSN));
            push_data[i] = term_hit[i] ? {1'b1, r3_new[i]}
                                       : {1'b0, 8'h00, r3_new[i][7:0]};
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    logic                  pick_found;
    logic [CORE_W-1:0]     pick_core;
    logic [CORE_W-1:0]     grant;
    logic                  hs;
    int unsigned           idx;

    always_comb begin
        pick_found = 1'b0;
        pick_core  = '0;
        idx        = 0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_CORES) begin
                idx = idx - NUM_CORES;
            end
            if (!pick_found && (cnt_q[idx] != '0)) begin
                pick_found = 1'b1;
                pick_core  = CORE_W'(idx);
            end
        end
    end

    // A stalled grant is held so a higher-priority core that becomes
    // non-empty cannot swap the presented event under backpressure.
    always_comb begin
        grant    = lock_q ? lock_core_q : pick_core;
        ev_valid = lock_q || pick_found;
        ev_core  = '0;
        ev_kind  = 1'b0;
        ev_data  = '0;
        if (ev_valid) begin
            ev_core = grant;
            {ev_kind, ev_data} = mem_q[grant][rd_ptr_q[grant]];
        end
        hs          = ev_valid && ev_ready;
        lock_d      = ev_valid && !ev_ready;
        lock_core_d = grant;
        rr_ptr_d    = rr_ptr_q;
        if (hs) begin
            rr_ptr_d = (grant == LAST_CORE) ? '0 : grant + CORE_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-core FIFOs, termination and overflow
    // ------------------------------------------------------------------
    logic                  pop_i     [NUM_CORES];
    logic                  push_ok   [NUM_CORES];

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        term_mask_d = term_mask_q;
        overflow_d  = overflow_q;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            pop_i[i]   = hs && (grant == CORE_W'(i));
            // A pop in the same cycle frees the slot the push needs.
            push_ok[i] = push[i] && ((cnt_q[i] != CNT_FULL) || pop_i[i]);
            if (push[i] && !push_ok[i]) begin
                overflow_d[i] = 1'b1;
            end
            if (term_hit[i]) begin
                term_mask_d[i] = 1'b1;
            end
            if (push_ok[i]) begin
                mem_d[i][wr_ptr_q[i]] = push_data[i];
                wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
            end
            if (pop_i[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
            end
            if (push_ok[i] && !pop_i[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!push_ok[i] && pop_i[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
        all_term_d = &term_mask_q;
    end

    // ------------------------------------------------------------------
    // Watchdog: saturates at TIMEOUT, frozen once every core terminated
    // ------------------------------------------------------------------
    always_comb begin
        wd_d      = wd_q;
        timeout_d = timeout_q;
        if (|trace_valid) begin
            wd_d = '0;
        end else if (!all_term_q && (wd_q != WD_MAX)) begin
            wd_d = wd_q + WD_W'(1);
        end
        if ((TIMEOUT != 0) && (wd_q == WD_MAX)) begin
            timeout_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                r3_q[i]     <= '0;
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            term_mask_q <= '0;
            overflow_q  <= '0;
            all_term_q  <= 1'b0;
            timeout_q   <= 1'b0;
            wd_q        <= '0;
            rr_ptr_q    <= '0;
            lock_q      <= 1'b0;
            lock_core_q <= '0;
        end else begin
            r3_q        <= r3_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            term_mask_q <= term_mask_d;
            overflow_q  <= overflow_d;
            all_term_q  <= all_term_d;
            timeout_q   <= timeout_d;
            wd_q        <= wd_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            lock_core_q <= lock_core_d;
        end
    end

    // Storage needs no reset: entries are only read while the count says valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign term_mask = term_mask_q;
    assign all_term  = all_term_q;
    assign overflow  = overflow_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_soc_msp430_trace_collector.sv
// Directed testbench for soc_msp430_trace_collector (4 cores, depth 4,
// watchdog of 10 idle cycles). Inputs are driven and outputs sampled on the
// falling clock edge; expected values are hand-computed constants.
module tb_soc_msp430_trace_collector;

    localparam int unsigned NC = 4;
    localparam logic [15:0] PUTC = 16'h4304;
    localparam logic [15:0] TERM = 16'h4305;
    localparam logic [15:0] MOV  = 16'h4034;

    logic             clk = 1'b0;
    logic             rst;
    logic [NC-1:0]    trace_valid;
    logic [NC*16-1:0] trace_insn;
    logic [NC-1:0]    trace_wben;
    logic [NC*4-1:0]  trace_wbreg;
    logic [NC*16-1:0] trace_wbdata;
    logic             ev_valid;
    logic             ev_ready;
    logic [1:0]       ev_core;
    logic             ev_kind;
    logic [15:0]      ev_data;
    logic [NC-1:0]    term_mask;
    logic             all_term;
    logic [NC-1:0]    overflow;
    logic             timeout;

    int n_tests = 0;
    int n_fail  = 0;

    soc_msp430_trace_collector #(
        .NUM_CORES  (NC),
        .FIFO_DEPTH (4),
        .PUTC_INSN  (PUTC),
        .TERM_INSN  (TERM),
        .TIMEOUT    (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .trace_valid  (trace_valid),
        .trace_insn   (trace_insn),
        .trace_wben   (trace_wben),
        .trace_wbreg  (trace_wbreg),
        .trace_wbdata (trace_wbdata),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_core      (ev_core),
        .ev_kind      (ev_kind),
        .ev_data      (ev_data),
        .term_mask    (term_mask),
        .all_term     (all_term),
        .overflow     (overflow),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_trace();
        trace_valid  = '0;
        trace_insn   = '0;
        trace_wben   = '0;
        trace_wbreg  = '0;
        trace_wbdata = '0;
    endtask

    task automatic set_core(input int unsigned c, input logic [15:0] insn,
                            input logic wben, input logic [3:0] wbreg,
                            input logic [15:0] wbdata);
        trace_valid[c]         = 1'b1;
        trace_insn[16*c +: 16] = insn;
        trace_wben[c]          = wben;
        trace_wbreg[4*c +: 4]  = wbreg;
        trace_wbdata[16*c +: 16] = wbdata;
    endtask

    task automatic check_ev(input string tag, input int core, input int kind, input int data);
        check({tag, "_valid"}, 32'(ev_valid), 1);
        check({tag, "_core"},  32'(ev_core),  32'(core));
        check({tag, "_kind"},  32'(ev_kind),  32'(kind));
        check({tag, "_data"},  32'(ev_data),  32'(data));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},    32'(ev_valid),  0);
        check({tag, "_core"},     32'(ev_core),   0);
        check({tag, "_kind"},     32'(ev_kind),   0);
        check({tag, "_data"},     32'(ev_data),   0);
        check({tag, "_term"},     32'(term_mask), 0);
        check({tag, "_allterm"},  32'(all_term),  0);
        check({tag, "_overflow"}, 32'(overflow),  0);
        check({tag, "_timeout"},  32'(timeout),   0);
    endtask

    int exp_core [4];
    int exp_data [4];

    initial begin
        rst      = 1'b1;
        ev_ready = 1'b0;
        clear_trace();
        repeat (3) step();
        rst = 1'b0;                       // now in cycle 0 after reset
        check_reset_outputs("reset");

        // Watchdog: no trace since reset, TIMEOUT=10 -> high in cycle 11
        repeat (10) step();
        check("wd_cycle10", 32'(timeout), 0);
        step();
        check("wd_cycle11", 32'(timeout), 1);

        // Fairness from pointer 0; each core writes R3 = 0x10+i with its putc
        ev_ready = 1'b1;
        for (int unsigned c = 0; c < NC; c++) set_core(c, PUTC, 1'b1, 4'd3, 16'h0010 + 16'(c));
        step();
        clear_trace();
        for (int k = 0; k < 4; k++) begin
            check_ev($sformatf("rr0_%0d", k), k, 0, 'h10 + k);
            step();
        end
        check("rr0_empty", 32'(ev_valid), 0);

        // Bypass: putc writing R3=0x1234 reports low byte only (pointer -> 2)
        set_core(1, PUTC, 1'b1, 4'd3, 16'h1234);
        step();
        clear_trace();
        check_ev("bypass", 1, 0, 'h0034);
        step();
        check("bypass_empty", 32'(ev_valid), 0);

        // Fairness from pointer 2, using shadow R3 values
        for (int unsigned c = 0; c < NC; c++) set_core(c, PUTC, 1'b0, 4'd0, 16'h0);
        step();
        clear_trace();
        exp_core = '{2, 3, 0, 1};
        exp_data = '{'h12, 'h13, 'h10, 'h34};
        for (int k = 0; k < 4; k++) begin
            check_ev($sformatf("rr2_%0d", k), exp_core[k], 0, exp_data[k]);
            step();
        end
        check("rr2_empty", 32'(ev_valid), 0);

        // Single core: write R3=0x41, then putc
        set_core(0, MOV, 1'b1, 4'd3, 16'h0041);
        step();
        clear_trace();
        check("mov_no_event", 32'(ev_valid), 0);
        set_core(0, PUTC, 1'b0, 4'd0, 16'h0);
        step();
        clear_trace();
        check_ev("putc41", 0, 0, 'h41);
        step();
        check("putc41_empty", 32'(ev_valid), 0);

        // Backpressure: 5 putcs on core 1 into a depth-4 FIFO
        ev_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            set_core(1, PUTC, 1'b1, 4'd3, 16'h0021 + 16'(n));
            step();
            clear_trace();
            check_ev($sformatf("bp_hold%0d", n), 1, 0, 'h21);
            check($sformatf("bp_ovf%0d", n), 32'(overflow), (n == 4) ? 32'h2 : 32'h0);
        end
        ev_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_ev($sformatf("bp_drain%0d", k), 1, 0, 'h21 + k);
            step();
        end
        check("bp_empty", 32'(ev_valid), 0);
        check("bp_ovf_sticky", 32'(overflow), 'h2);

        // Reset mid-operation with an event queued
        ev_ready = 1'b0;
        set_core(3, PUTC, 1'b1, 4'd3, 16'h0077);
        step();
        clear_trace();
        check_ev("pre_rst", 3, 0, 'h77);
        check("pre_rst_timeout", 32'(timeout), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("midrst");
        ev_ready = 1'b1;

        // Terminate core 0 with R3=7
        set_core(0, MOV, 1'b1, 4'd3, 16'h0007);
        step();
        clear_trace();
        set_core(0, TERM, 1'b0, 4'd0, 16'h0);
        step();
        clear_trace();
        check_ev("term0", 0, 1, 7);
        check("term0_mask", 32'(term_mask), 'h1);
        check("term0_all", 32'(all_term), 0);
        step();
        check("term0_empty", 32'(ev_valid), 0);

        // Terminate core 2 with bypassed R3, then its putc is ignored
        set_core(2, TERM, 1'b1, 4'd3, 16'h0abc);
        step();
        clear_trace();
        check_ev("term2", 2, 1, 'h0abc);
        check("term2_mask", 32'(term_mask), 'h5);
        set_core(2, PUTC, 1'b1, 4'd3, 16'h0055);
        step();
        clear_trace();
        check("post_term_no_event", 32'(ev_valid), 0);

        // Cores 1 and 3 terminate together (pointer at 3)
        set_core(1, TERM, 1'b0, 4'd0, 16'h0);
        set_core(3, TERM, 1'b0, 4'd0, 16'h0);
        step();
        clear_trace();
        check_ev("term3", 3, 1, 0);
        check("all_mask", 32'(term_mask), 'hf);
        check("all_term_t1", 32'(all_term), 0);
        step();
        check_ev("term1", 1, 1, 0);
        check("all_term_t2", 32'(all_term), 1);
        step();
        check("all_empty", 32'(ev_valid), 0);
        repeat (15) step();
        check("wd_frozen", 32'(timeout), 0);
        check("all_term_hold", 32'(all_term), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
